acc_seq_ctrl: RTL

Sequencer and port arbiter for the minimum-finder accelerator: on a start pulse it clears the accelerator and streams `len` words from a synchronous-read memory into it. It then reads back the minimum and presents it as `result` with a one-cycle `done` pulse. While idle, the accelerator port is passed through to the CPU bus, so software can still drive the accelerator directly.

---
 rtl/acc_seq_pkg.sv | 30 +++
 rtl/PipeReg.sv | 17 +
 rtl/acc_seq_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared types and constants for the minimum-finder sequencer.
package acc_seq_pkg;

  localparam int unsigned ACC_AW = 4;
  localparam int unsigned ACC_DW = 32;

  // Accelerator register offsets
  localparam logic [ACC_AW-1:0] ACC_DATA  = 4'd0;
  localparam logic [ACC_AW-1:0] ACC_MIN   = 4'd1;
  localparam logic [ACC_AW-1:0] ACC_CLEAR = 4'd2;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    DRAIN,
    RD_REQ,
    RD_CAP,
    DONE
  } state_t;

  // One accelerator port access
  typedef struct packed {
    logic              en;
    logic              we;
    logic [ACC_AW-1:0] addr;
    logic [ACC_DW-1:0] din;
  } acc_req_t;

endpackage

// File: rtl/PipeReg.sv
// PipeReg: plain W-bit pipeline register with synchronous active-high clear.
module PipeReg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // One-cycle delay, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) q <= '0;
    else     q <= d;
  end

endmodule

// File: rtl/acc_seq_ctrl.sv
// acc_seq_ctrl: streams a memory block into the minimum-finder accelerator,
// reads back the minimum and arbitrates the accelerator port with the CPU.
// Optional build macro ACC_SEQ_ABORT_EN adds the abort/aborted ports.
module acc_seq_ctrl
  import acc_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned LEN_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [31:0]       result,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout,
  input  logic              cpu_en,
  input  logic              cpu_we,
  input  logic [3:0]        cpu_addr,
  input  logic [31:0]       cpu_din,
  output logic [31:0]       cpu_dout,
`ifdef ACC_SEQ_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              acc_en,
  output logic              acc_we,
  output logic [3:0]        acc_addr,
  output logic [31:0]       acc_din,
  input  logic [31:0]       acc_dout
);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  idx;
  logic              wr_pend;
  logic              own_q;
  logic              aborting;
  logic              abort_req;
  acc_req_t          req;

`ifdef ACC_SEQ_ABORT_EN
  assign abort_req = abort && (state != IDLE);
`else
  assign abort_req = 1'b0;
`endif

  // Memory data lands one cycle after the read, so write it one cycle later
  PipeReg #(.W(1)) u_wr_pend (
    .clk (clk),
    .rst (rst),
    .d   (mem_en),
    .q   (wr_pend)
  );

  // Remember whether the last accelerator access came from the CPU
  PipeReg #(.W(1)) u_own (
    .clk (clk),
    .rst (rst),
    .d   ((state == IDLE) && cpu_en),
    .q   (own_q)
  );

  assign cpu_dout = own_q ? acc_dout : 32'h0;

  // Sequencer FSM with registered status, memory and result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= 32'h0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
      idx      <= '0;
      base_q   <= '0;
      len_q    <= '0;
      aborting <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort_req) begin
        state    <= CLEAR;
        aborting <= 1'b1;
        mem_en   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              base_q <= base;
              len_q  <= len;
              idx    <= '0;
              busy   <= 1'b1;
              state  <= CLEAR;
            end
          end
          CLEAR: begin
            if (aborting) begin
              aborting <= 1'b0;
              busy     <= 1'b0;
              state    <= IDLE;
            end else if (len_q != '0) begin
              mem_en   <= 1'b1;
              mem_addr <= base_q;
              state    <= STREAM;
            end else begin
              state <= RD_REQ;
            end
          end
          STREAM: begin
            if (idx == len_q - LEN_W'(1)) begin
              mem_en <= 1'b0;
              state  <= DRAIN;
            end else begin
              idx      <= idx + LEN_W'(1);
              mem_addr <= base_q + ADDR_W'(idx + LEN_W'(1));
            end
          end
          DRAIN:  state <= RD_REQ;
          RD_REQ: state <= RD_CAP;
          RD_CAP: begin
            result <= acc_dout;
            done   <= 1'b1;
            state  <= DONE;
          end
          DONE: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

`ifdef ACC_SEQ_ABORT_EN
  // Pulse when an aborted job's clear finishes and IDLE is re-entered
  always_ff @(posedge clk) begin
    if (rst) aborted <= 1'b0;
    else     aborted <= (state == CLEAR) && aborting && !abort_req;
  end
`endif

  // Accelerator port owner: CPU while idle, sequencer otherwise
  always_comb begin
    req = '0;
    case (state)
      IDLE: begin
        req.en   = cpu_en;
        req.we   = cpu_we;
        req.addr = cpu_addr;
        req.din  = cpu_din;
      end
      CLEAR: begin
        req.en   = 1'b1;
        req.we   = 1'b1;
        req.addr = ACC_CLEAR;
      end
      STREAM: begin
        req.en   = wr_pend;
        req.we   = wr_pend;
        req.addr = ACC_DATA;
        req.din  = mem_dout;
      end
      DRAIN: begin
        req.en   = 1'b1;
        req.we   = 1'b1;
        req.addr = ACC_DATA;
        req.din  = mem_dout;
      end
      RD_REQ: begin
        req.en   = 1'b1;
        req.addr = ACC_MIN;
      end
      default: ;
    endcase
  end

  assign acc_en   = req.en;
  assign acc_we   = req.we;
  assign acc_addr = req.addr;
  assign acc_din  = req.din;

endmodule
